// File: rtl/ksa_pg_stage.sv
// ksa_pg_stage: registered propagate/generate pre-stage for a Kogge-Stone adder,
// valid/ready on both sides with a two-entry skid so in_ready never depends on out_ready.
module ksa_pg_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] p_out,
    output logic [WIDTH-1:0] g_out,
    output logic             cin_out
);
    localparam int BW = 2 * WIDTH + 1;

    logic [BW-1:0] main_q, main_d, skid_q, skid_d, in_beat;
    logic          main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic          accept, load;

    assign in_beat = {a ^ b, a & b, cin};
    assign accept  = in_valid && !skid_v_q;
    assign load    = !main_v_q || out_ready;

    always_comb begin
        main_d   = main_q;
        main_v_d = main_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (load) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else begin
                main_v_d = accept;
                main_d   = accept ? in_beat : main_q;
            end
        end else if (accept) begin
            // main is stalled, so the new beat parks in the skid
            skid_d   = in_beat;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q   <= '0;
            main_v_q <= 1'b0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
        end else begin
            main_q   <= main_d;
            main_v_q <= main_v_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
        end
    end

    assign in_ready  = !skid_v_q;
    assign out_valid = main_v_q;
    assign p_out     = main_q[BW-1 -: WIDTH];
    assign g_out     = main_q[WIDTH -: WIDTH];
    assign cin_out   = main_q[0];
endmodule

// File: tb/tb_ksa_pg_stage.sv
// tb_ksa_pg_stage: directed and random traffic for ksa_pg_stage; stimulus pushes
// expected beats into a queue, a negedge monitor pops and compares them.
module tb_ksa_pg_stage;
    localparam int W = 16;

    logic         clk = 0, rst_n = 0, in_valid = 0, cin = 0, out_ready = 0;
    logic         in_ready, out_valid, cin_out;
    logic [W-1:0] a = '0, b = '0, p_out, g_out;
    logic [2*W:0] q[$];
    logic [2*W:0] held_v;
    logic         held = 0;
    int           n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    ksa_pg_stage #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .p_out(p_out), .g_out(g_out), .cin_out(cin_out)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Queue size at the negedge equals the DUT occupancy for the current cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready_vs_occupancy", {63'd0, in_ready}, {63'd0, q.size() < 2});
            chk("out_valid_vs_occupancy", {63'd0, out_valid}, {63'd0, q.size() > 0});
            if (held)
                chk("stall_hold", {30'd0, out_valid, p_out, g_out, cin_out}, {30'd0, 1'b1, held_v});
            if (out_valid && q.size() > 0) begin
                chk("data", {30'd0, p_out, g_out, cin_out}, {31'd0, q[0]});
                if (out_ready) void'(q.pop_front());
            end
            held   = out_valid && !out_ready;
            held_v = {p_out, g_out, cin_out};
        end else begin
            held = 0;
        end
    end

    task automatic step(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input logic [W-1:0] ep, input logic [W-1:0] eg,
                        input logic rdy, output logic acc);
        @(posedge clk);
        #1;
        in_valid = v; a = ta; b = tb_; cin = tc; out_ready = rdy;
        @(negedge clk);
        acc = in_valid && in_ready;
        #1;
        if (acc) q.push_back({ep, eg, tc});
    endtask

    task automatic idle(input logic rdy);
        logic acc;
        step(1'b0, '0, '0, 1'b0, '0, '0, rdy, acc);
    endtask

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic [W-1:0] ep, input logic [W-1:0] eg, input logic rdy);
        logic acc;
        acc = 0;
        for (int i = 0; i < 50 && !acc; i++) step(1'b1, ta, tb_, tc, ep, eg, rdy, acc);
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc, acc;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_pg", {30'd0, p_out, g_out, cin_out}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1;

        send(16'h00FF, 16'h0F0F, 1'b1, 16'h0FF0, 16'h000F, 1'b1);
        idle(1'b1);
        chk("single_beat", {31'd0, out_valid, p_out, g_out, cin_out}, {31'd0, 1'b1, 16'h0FF0, 16'h000F, 1'b1});

        send(16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF, 1'b1);
        send(16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b1);
        chk("boundary_ones", {31'd0, out_valid, p_out, g_out, cin_out}, {31'd0, 1'b1, 16'h0000, 16'hFFFF, 1'b0});
        idle(1'b1);
        chk("boundary_zeros", {31'd0, out_valid, p_out, g_out, cin_out}, {31'd0, 1'b1, 16'h0000, 16'h0000, 1'b1});
        idle(1'b1);

        for (int i = 0; i < 100; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            step(1'b1, ra, rb, rc, ra ^ rb, ra & rb, 1'b1, acc);
            chk("stream_accept", {63'd0, acc}, 64'd1);
            if (i > 0) chk("stream_no_bubble", {63'd0, out_valid}, 64'd1);
        end
        idle(1'b1);
        idle(1'b1);

        send(16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 16'h0001, 1'b0);
        send(16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
        idle(1'b0);
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("bp_hold", {32'd0, p_out, g_out}, {32'd0, 16'hFFFE, 16'h0001});
        idle(1'b0);
        idle(1'b1);
        chk("bp_first_out", {32'd0, p_out, g_out}, {32'd0, 16'hFFFE, 16'h0001});
        idle(1'b1);
        chk("bp_second_out", {32'd0, p_out, g_out}, {32'd0, 16'hFFFF, 16'h0000});
        idle(1'b1);
        chk("bp_in_ready_back", {63'd0, in_ready}, 64'd1);

        send(16'h1234, 16'h4321, 1'b1, 16'h1234 ^ 16'h4321, 16'h1234 & 16'h4321, 1'b0);
        send(16'h5678, 16'h8765, 1'b1, 16'h5678 ^ 16'h8765, 16'h5678 & 16'h8765, 1'b0);
        idle(1'b0);
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_pg", {30'd0, p_out, g_out, cin_out}, 64'd0);
        q.delete();
        @(posedge clk);
        #1 rst_n = 1;
        repeat (3) idle(1'b1);

        for (int i = 0; i < 10000; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            step($urandom_range(0, 3) != 0, ra, rb, rc, ra ^ rb, ra & rb, 1'($urandom), acc);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) idle(1'b1);
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
